// File: rtl/usb_tx_packet_fsm.sv
// USB low/full-speed packet transmitter. Takes packet bytes over a
// valid/ready handshake and drives SYNC, NRZI-encoded bit-stuffed data
// and EOP onto the {dp,dm} line pair, one bit per clock.
module usb_tx_packet_fsm #(
  parameter logic [1:0] LS_J = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [1:0] usb_line_state,
  output logic       tx_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       error
);

  localparam logic [1:0] LS_K   = ~LS_J;
  localparam logic [1:0] LS_SE0 = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    STUFF   = 3'd3,
    EOP_SE0 = 3'd4,
    EOP_J   = 3'd5
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [2:0] ones_cnt;
  logic [7:0] shift_reg;
  logic       last_flag;
  logic       eop_pending;
  logic       underrun;
  logic       se0_cnt;

  logic       cur_bit;
  logic [2:0] ones_after;
  logic       stuff_due;
  logic       next_data_bit;
  logic [1:0] data_level;
  logic [1:0] sync_level;
  logic [1:0] resume_level;
  logic [1:0] toggled_level;

  // Decode the bit on the line now and the NRZI level of whatever bit comes next.
  always_comb begin
    cur_bit = 1'b0;
    if (state == SYNC) begin
      cur_bit = (bit_cnt == 3'd7);
    end else if (state == DATA) begin
      cur_bit = shift_reg[0];
    end
    ones_after    = cur_bit ? (ones_cnt + 3'd1) : 3'd0;
    stuff_due     = (ones_after == 3'd6);
    next_data_bit = (bit_cnt == 3'd7) ? tx_data[0] : shift_reg[1];
    toggled_level = ~usb_line_state;
    data_level    = next_data_bit ? usb_line_state : toggled_level;
    sync_level    = (bit_cnt == 3'd6) ? usb_line_state : toggled_level;
    resume_level  = shift_reg[0] ? usb_line_state : toggled_level;
  end

  // Handshake and status strobes decoded from the registered state; an underrun
  // is flagged in the very ready cycle that finds no byte waiting.
  always_comb begin
    tx_ready = ((state == SYNC) && (bit_cnt == 3'd7)) ||
               ((state == DATA) && (bit_cnt == 3'd7) && !last_flag);
    error    = tx_ready && !tx_valid;
    tx_done  = (state == EOP_J) && !underrun;
    busy     = (state != IDLE);
  end

  // Packet sequencer; line drive and output enable move in lockstep with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      ones_cnt       <= 3'd0;
      shift_reg      <= 8'd0;
      last_flag      <= 1'b0;
      eop_pending    <= 1'b0;
      underrun       <= 1'b0;
      se0_cnt        <= 1'b0;
      usb_line_state <= LS_J;
      tx_oe          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          usb_line_state <= LS_J;
          tx_oe          <= 1'b0;
          if (tx_valid) begin
            state          <= SYNC;
            bit_cnt        <= 3'd0;
            ones_cnt       <= 3'd0;
            underrun       <= 1'b0;
            eop_pending    <= 1'b0;
            usb_line_state <= LS_K;
            tx_oe          <= 1'b1;
          end
        end

        SYNC: begin
          ones_cnt <= ones_after;
          if (bit_cnt != 3'd7) begin
            bit_cnt        <= bit_cnt + 3'd1;
            usb_line_state <= sync_level;
          end else if (tx_valid) begin
            shift_reg      <= tx_data;
            last_flag      <= tx_last;
            bit_cnt        <= 3'd0;
            state          <= DATA;
            usb_line_state <= data_level;
          end else begin
            underrun       <= 1'b1;
            se0_cnt        <= 1'b0;
            state          <= EOP_SE0;
            usb_line_state <= LS_SE0;
          end
        end

        DATA: begin
          ones_cnt <= ones_after;
          if (bit_cnt != 3'd7) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 3'd1;
            if (stuff_due) begin
              state          <= STUFF;
              usb_line_state <= toggled_level;
            end else begin
              usb_line_state <= data_level;
            end
          end else if (!last_flag) begin
            if (tx_valid) begin
              shift_reg <= tx_data;
              last_flag <= tx_last;
              bit_cnt   <= 3'd0;
              if (stuff_due) begin
                state          <= STUFF;
                usb_line_state <= toggled_level;
              end else begin
                usb_line_state <= data_level;
              end
            end else begin
              underrun       <= 1'b1;
              se0_cnt        <= 1'b0;
              state          <= EOP_SE0;
              usb_line_state <= LS_SE0;
            end
          end else begin
            bit_cnt <= 3'd0;
            if (stuff_due) begin
              eop_pending    <= 1'b1;
              state          <= STUFF;
              usb_line_state <= toggled_level;
            end else begin
              se0_cnt        <= 1'b0;
              state          <= EOP_SE0;
              usb_line_state <= LS_SE0;
            end
          end
        end

        STUFF: begin
          ones_cnt <= 3'd0;
          if (eop_pending) begin
            eop_pending    <= 1'b0;
            se0_cnt        <= 1'b0;
            state          <= EOP_SE0;
            usb_line_state <= LS_SE0;
          end else begin
            state          <= DATA;
            usb_line_state <= resume_level;
          end
        end

        EOP_SE0: begin
          if (!se0_cnt) begin
            se0_cnt <= 1'b1;
          end else begin
            se0_cnt        <= 1'b0;
            state          <= EOP_J;
            usb_line_state <= LS_J;
          end
        end

        EOP_J: begin
          state          <= IDLE;
          usb_line_state <= LS_J;
          tx_oe          <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          usb_line_state <= LS_J;
          tx_oe          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_packet_fsm.sv
// Self-checking bench for usb_tx_packet_fsm: a bit-stream reference model
// builds the expected line sequence and strobes for each packet.
module tb_usb_tx_packet_fsm;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [1:0] usb_line_state;
  logic       tx_oe;
  logic       busy;
  logic       tx_done;
  logic       error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pkt_bytes[$];
  logic [1:0] exp_line[$];
  bit         exp_ready[$];
  bit         exp_err[$];
  bit         exp_done[$];
  logic [1:0] m_level;
  int         m_ones;

  usb_tx_packet_fsm #(.LS_J(J)) dut (
    .clk            (clk),
    .reset          (reset),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_last        (tx_last),
    .tx_ready       (tx_ready),
    .usb_line_state (usb_line_state),
    .tx_oe          (tx_oe),
    .busy           (busy),
    .tx_done        (tx_done),
    .error          (error)
  );

  // Free-running bit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One line bit of the model: NRZI encode and track the run of ones.
  task automatic emit(input bit b, input bit rdy, input bit err);
    if (!b) m_level = ~m_level;
    exp_line.push_back(m_level);
    exp_ready.push_back(rdy);
    exp_err.push_back(err);
    exp_done.push_back(1'b0);
    m_ones = b ? m_ones + 1 : 0;
  endtask

  // Build expected cycle-by-cycle outputs for pkt_bytes, with only n_deliver bytes offered.
  task automatic buildModel(input int n_deliver);
    bit under;
    int n;
    exp_line.delete(); exp_ready.delete(); exp_err.delete(); exp_done.delete();
    m_level = J;
    m_ones  = 0;
    n       = pkt_bytes.size();
    for (int s = 0; s < 7; s++) emit(1'b0, 1'b0, 1'b0);
    under = (n_deliver == 0);
    emit(1'b1, 1'b1, under);
    for (int j = 0; j < n_deliver && !under; j++) begin
      for (int k = 0; k < 8 && !under; k++) begin
        bit rdy;
        rdy   = (k == 7) && (j < n - 1);
        under = rdy && (j + 1 >= n_deliver);
        emit(pkt_bytes[j][k], rdy, under);
        if (!under && m_ones == 6) emit(1'b0, 1'b0, 1'b0);
      end
    end
    for (int e = 0; e < 3; e++) begin
      exp_line.push_back(e < 2 ? SE0 : J);
      exp_ready.push_back(1'b0);
      exp_err.push_back(1'b0);
      exp_done.push_back(e == 2 && !under);
    end
  endtask

  // Send pkt_bytes, dropping tx_valid after n_deliver accepted bytes, checking every cycle.
  task automatic applyStimulus(input string name, input int n_deliver);
    int  idx;
    bit  xfer;
    buildModel(n_deliver);
    idx = 0;
    @(negedge clk);
    tx_data  = pkt_bytes[0];
    tx_last  = (pkt_bytes.size() == 1);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    if (n_deliver == 0) tx_valid = 1'b0;
    for (int i = 0; i < exp_line.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s line[%0d]", name, i), usb_line_state, exp_line[i]);
      checkOutput($sformatf("%s oe[%0d]", name, i), tx_oe, 1);
      checkOutput($sformatf("%s busy[%0d]", name, i), busy, 1);
      checkOutput($sformatf("%s ready[%0d]", name, i), tx_ready, exp_ready[i]);
      checkOutput($sformatf("%s error[%0d]", name, i), error, exp_err[i]);
      checkOutput($sformatf("%s done[%0d]", name, i), tx_done, exp_done[i]);
      xfer = tx_ready && tx_valid;
      @(posedge clk); #1;
      if (xfer) begin
        idx++;
        if (idx < n_deliver) begin
          tx_data = pkt_bytes[idx];
          tx_last = (idx == pkt_bytes.size() - 1);
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    checkOutput($sformatf("%s idle line", name), usb_line_state, J);
    checkOutput($sformatf("%s idle oe", name), tx_oe, 0);
    checkOutput($sformatf("%s idle busy", name), busy, 0);
    checkOutput($sformatf("%s idle ready", name), tx_ready, 0);
  endtask

  initial begin
    int len;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset line", usb_line_state, J);
    checkOutput("reset oe", tx_oe, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset ready", tx_ready, 0);
    checkOutput("reset done", tx_done, 0);
    checkOutput("reset error", error, 0);
    reset = 1'b0;

    pkt_bytes = '{8'h00};        applyStimulus("byte00", 1);
    pkt_bytes = '{8'hFF};        applyStimulus("byteFF", 1);
    pkt_bytes = '{8'hA5, 8'h3C}; applyStimulus("a5_3c", 2);
    pkt_bytes = '{8'hFF, 8'hFF}; applyStimulus("ff_ff", 2);
    pkt_bytes = '{8'h81, 8'h42}; applyStimulus("underrun", 1);
    pkt_bytes = '{8'h7E};        applyStimulus("underrun_sync", 0);

    for (int r = 0; r < 8; r++) begin
      pkt_bytes.delete();
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) pkt_bytes.push_back(8'($urandom));
      applyStimulus($sformatf("rand%0d", r), (r == 5) ? len - 1 : len);
    end

    // Abort in the middle of the data phase, then start a fresh packet.
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_last  = 1'b0;
    tx_valid = 1'b1;
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort line", usb_line_state, J);
    checkOutput("abort oe", tx_oe, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort ready", tx_ready, 0);
    tx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort idle busy", busy, 0);
    pkt_bytes = '{8'hC3};
    applyStimulus("after_abort", 1);

    $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
